// File: rtl/sd_search_ctrl.sv
// Depth-first sphere-decoder search controller: walks a 4-level, 8-ary symbol tree,
// pruning on the shrinking squared radius and recording the best leaf found.
module sd_search_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] radius_in,
  input  logic [15:0]      node_limit,
  input  logic [WIDTH-1:0] node_cost,
  output logic [2:0]       sym_0,
  output logic [2:0]       sym_1,
  output logic [2:0]       sym_2,
  output logic [2:0]       sym_3,
  output logic [1:0]       node_lvl,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             timeout,
  output logic [2:0]       best_0,
  output logic [2:0]       best_1,
  output logic [2:0]       best_2,
  output logic [2:0]       best_3,
  output logic [WIDTH-1:0] best_cost,
  output logic [15:0]      node_count,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a one-cycle request honoured only in IDLE; done pulses once
  // per finished search, and results stay stable until the next accepted start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    ADV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] radius_q, radius_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [3:0][2:0]  sym_q, sym_d;
  logic [3:0][2:0]  best_q, best_d;
  logic             found_q, found_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      limit_q, limit_d;
  logic             do_adv;
  logic             below;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      radius_q  <= '0;
      lvl_q     <= '0;
      sym_q     <= '0;
      best_q    <= '0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      limit_q   <= '0;
    end else begin
      state_q   <= state_d;
      radius_q  <= radius_d;
      lvl_q     <= lvl_d;
      sym_q     <= sym_d;
      best_q    <= best_d;
      found_q   <= found_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    radius_d  = radius_q;
    lvl_d     = lvl_q;
    sym_d     = sym_q;
    best_d    = best_q;
    found_d   = found_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    limit_d   = limit_q;
    do_adv    = 1'b0;
    below     = node_cost < radius_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          radius_d  = radius_in;
          limit_d   = node_limit;
          lvl_d     = 2'd3;
          sym_d     = '0;
          best_d    = '0;
          count_d   = '0;
          found_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        if (below && lvl_q != 2'd0) begin
          lvl_d                 = lvl_q - 2'd1;
          sym_d[lvl_q - 2'd1]   = 3'd0;
        end else begin
          if (below) begin
            best_d   = sym_q;
            radius_d = node_cost;
            found_d  = 1'b1;
          end
          do_adv = 1'b1;
        end
        // Hitting the node budget keeps this cycle's leaf result but stops the walk.
        if (limit_q != 16'd0 && count_d == limit_q) begin
          do_adv    = 1'b0;
          lvl_d     = lvl_q;
          sym_d     = sym_q;
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      ADV:  do_adv  = 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_adv) begin
      if (sym_q[lvl_q] != 3'd7) begin
        sym_d[lvl_q] = sym_q[lvl_q] + 3'd1;
        state_d      = EVAL;
      end else if (lvl_q == 2'd3) begin
        state_d = DONE;
      end else begin
        lvl_d   = lvl_q + 2'd1;
        state_d = ADV;
      end
    end
  end

  assign sym_0      = sym_q[0];
  assign sym_1      = sym_q[1];
  assign sym_2      = sym_q[2];
  assign sym_3      = sym_q[3];
  assign node_lvl   = lvl_q;
  assign busy       = (state_q == EVAL) || (state_q == ADV);
  assign done       = (state_q == DONE);
  assign found      = found_q;
  assign timeout    = timeout_q;
  assign best_0     = best_q[0];
  assign best_1     = best_q[1];
  assign best_2     = best_q[2];
  assign best_3     = best_q[3];
  assign best_cost  = radius_q;
  assign node_count = count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sd_search_ctrl.sv
// Bench for sd_search_ctrl: a partial-distance metric table stands in for metric_calc,
// and a nested-loop tree search model supplies every expected result.
module tb_sd_search_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] radius_in, node_cost, best_cost;
  logic [15:0]  node_limit, node_count;
  logic [2:0]   sym_0, sym_1, sym_2, sym_3, best_0, best_1, best_2, best_3;
  logic [1:0]   node_lvl, state_dbg;
  logic         busy, done, found, timeout;

  sd_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .radius_in(radius_in),
    .node_limit(node_limit), .node_cost(node_cost),
    .sym_0(sym_0), .sym_1(sym_1), .sym_2(sym_2), .sym_3(sym_3), .node_lvl(node_lvl),
    .busy(busy), .done(done), .found(found), .timeout(timeout),
    .best_0(best_0), .best_1(best_1), .best_2(best_2), .best_3(best_3),
    .best_cost(best_cost), .node_count(node_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Metric: partial distance = sum of per-level increments from the root down to node_lvl.
  logic [W-1:0] inc[4][8];
  logic [2:0]   cur_sym[4];
  assign cur_sym[0] = sym_0;
  assign cur_sym[1] = sym_1;
  assign cur_sym[2] = sym_2;
  assign cur_sym[3] = sym_3;

  always_comb begin
    node_cost = '0;
    for (int l = 0; l < 4; l++)
      if (l >= int'(node_lvl)) node_cost = node_cost + inc[l][cur_sym[l]];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference search state
  logic [W-1:0] m_r;
  int           m_count;
  bit           m_stop, m_found;
  logic [11:0]  m_best;

  function automatic logic [W-1:0] m_cost(input int lvl, input int s3, input int s2,
                                           input int s1, input int s0);
    int s[4];
    logic [W-1:0] c;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    c = '0;
    for (int l = lvl; l < 4; l++) c = c + inc[l][s[l]];
    return c;
  endfunction

  task automatic m_visit(input int lvl, input int s3, input int s2, input int s1, input int s0,
                         input int limit, output bit go);
    logic [W-1:0] c;
    bit lt;
    if (m_count < 65535) m_count++;
    c  = m_cost(lvl, s3, s2, s1, s0);
    lt = c < m_r;
    if (lvl == 0 && lt) begin
      m_r     = c;
      m_found = 1'b1;
      m_best  = {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    end
    if (limit != 0 && m_count == limit) m_stop = 1'b1;
    go = lt && lvl > 0 && !m_stop;
  endtask

  task automatic run_model(input logic [W-1:0] radius, input int limit);
    bit g3, g2, g1, g0;
    m_r = radius; m_count = 0; m_stop = 0; m_found = 0; m_best = '0;
    for (int s3 = 0; s3 < 8 && !m_stop; s3++) begin
      m_visit(3, s3, 0, 0, 0, limit, g3);
      for (int s2 = 0; g3 && s2 < 8 && !m_stop; s2++) begin
        m_visit(2, s3, s2, 0, 0, limit, g2);
        for (int s1 = 0; g2 && s1 < 8 && !m_stop; s1++) begin
          m_visit(1, s3, s2, s1, 0, limit, g1);
          for (int s0 = 0; g1 && s0 < 8 && !m_stop; s0++)
            m_visit(0, s3, s2, s1, s0, limit, g0);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_sym"},   {sym_3, sym_2, sym_1, sym_0}, 0);
    check_val({tag, "_lvl"},   node_lvl, 0);
    check_val({tag, "_busy"},  busy, 0);
    check_val({tag, "_done"},  done, 0);
    check_val({tag, "_found"}, found, 0);
    check_val({tag, "_tmo"},   timeout, 0);
    check_val({tag, "_best"},  {best_3, best_2, best_1, best_0}, 0);
    check_val({tag, "_cost"},  best_cost, 0);
    check_val({tag, "_cnt"},   node_count, 0);
  endtask

  task automatic fill_inc(input int maxv);
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < 8; s++) inc[l][s] = W'($urandom_range(0, maxv));
  endtask

  task automatic run_search(input string tag, input logic [W-1:0] radius, input int limit,
                            input bit noise, input int exp_busy);
    int busy_cnt;
    bit seen;
    run_model(radius, limit);
    @(negedge clk);
    start = 1'b1; radius_in = radius; node_limit = 16'(limit);
    @(negedge clk);
    start = 1'b0;
    if (noise) begin
      radius_in  = W'($urandom);
      node_limit = 16'($urandom_range(1, 3));
    end
    busy_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (noise) start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    check_val({tag, "_done_seen"}, seen, 1);
    if (!seen) return;
    check_val({tag, "_busy_in_done"}, busy, 0);
    if (exp_busy >= 0) check_val({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check_val({tag, "_found"}, found, m_found);
    check_val({tag, "_timeout"}, timeout, m_stop);
    check_val({tag, "_best"}, {best_3, best_2, best_1, best_0}, m_best);
    check_val({tag, "_cost"}, best_cost, m_r);
    check_val({tag, "_count"}, node_count, m_count);
    start = noise;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_done_pulse"}, done, 0);
    repeat (2) @(negedge clk);
    check_val({tag, "_hold_busy"}, busy, 0);
    check_val({tag, "_hold_found"}, found, m_found);
    check_val({tag, "_hold_cost"}, best_cost, m_r);
    check_val({tag, "_hold_count"}, node_count, m_count);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; radius_in = '0; node_limit = '0;
    fill_inc(0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int l = 0; l < 4; l++) for (int s = 0; s < 8; s++) inc[l][s] = '0;
    run_search("full_zero", 1, 0, 1'b0, 35);
    run_search("radius0", 0, 0, 1'b0, 8);
    run_search("limit5", 1, 5, 1'b0, 5);
    run_search("noise_zero", 1, 0, 1'b1, 35);

    // Reset in the middle of a search, colliding with a start request.
    begin
      bit hit;
      hit = 1'b0;
      @(negedge clk);
      start = 1'b1; radius_in = 1; node_limit = 0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        if (node_count == 16'd10) hit = 1'b1;
        else @(negedge clk);
      end
      check_val("midrst_reach10", hit, 1);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check_zero("midrst");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check_val("midrst_idle_busy", busy, 0);
      check_val("midrst_idle_done", done, 0);
    end
    run_search("after_rst", 1, 0, 1'b0, 35);

    for (int t = 0; t < 24; t++) begin
      logic [W-1:0] r;
      int lim;
      fill_inc((t % 3 == 0) ? 3 : 40);
      r   = ($urandom_range(0, 1) == 1) ? '1 : W'($urandom_range(0, 150));
      lim = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 300);
      run_search($sformatf("rand%0d", t), r, lim, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
